// File: rtl/vend_pkg.sv
// Shared types and coin encoding for the multi-product vending controller.
// Coin vectors are always ordered {1000, 500, 100, 50}, highest priority first.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MANAGE,
    S_CREDIT,
    S_SELECTED,
    S_MAKING,
    S_SERVE,
    S_CHANGE
  } state_e;

  localparam int COIN_W = 5;

  localparam logic [COIN_W-1:0] UNIT_50   = 5'd1;
  localparam logic [COIN_W-1:0] UNIT_100  = 5'd2;
  localparam logic [COIN_W-1:0] UNIT_500  = 5'd10;
  localparam logic [COIN_W-1:0] UNIT_1000 = 5'd20;

  localparam int C50   = 0;
  localparam int C100  = 1;
  localparam int C500  = 2;
  localparam int C1000 = 3;

  // Keep only the most valuable coin of a same-cycle burst.
  function automatic logic [3:0] coin_pick(input logic [3:0] c);
    logic [3:0] r;
    r = 4'b0000;
    if (c[C1000])     r[C1000] = 1'b1;
    else if (c[C500]) r[C500]  = 1'b1;
    else if (c[C100]) r[C100]  = 1'b1;
    else if (c[C50])  r[C50]   = 1'b1;
    return r;
  endfunction

  function automatic logic [COIN_W-1:0] coin_units(input logic [3:0] oh);
    logic [COIN_W-1:0] u;
    u = '0;
    if (oh[C1000])     u = UNIT_1000;
    else if (oh[C500]) u = UNIT_500;
    else if (oh[C100]) u = UNIT_100;
    else if (oh[C50])  u = UNIT_50;
    return u;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy change selector: picks the largest coin not exceeding the credit
// and reports it as a one-hot eject vector plus the amount to subtract.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int SUM_W = 8
) (
  input  logic [SUM_W-1:0] sum_i,
  output logic [3:0]       eject_o,
  output logic [SUM_W-1:0] sub_o
);

  logic [SUM_W+COIN_W-1:0] sum_x;

  assign sum_x = {{COIN_W{1'b0}}, sum_i};

  always_comb begin
    eject_o = 4'b0000;
    if (sum_x >= (SUM_W+COIN_W)'(UNIT_1000))     eject_o[C1000] = 1'b1;
    else if (sum_x >= (SUM_W+COIN_W)'(UNIT_500)) eject_o[C500]  = 1'b1;
    else if (sum_x >= (SUM_W+COIN_W)'(UNIT_100)) eject_o[C100]  = 1'b1;
    else if (sum_x >= (SUM_W+COIN_W)'(UNIT_50))  eject_o[C50]   = 1'b1;
  end

  assign sub_o = SUM_W'(coin_units(eject_o));

endmodule

// File: rtl/vend_core_multi.sv
// Multi-product vending controller: coin credit, programmable prices and
// stock, brewer handshake and one-coin-per-cycle greedy change return.
//
// state      | meaning
// S_IDLE     | no credit, waiting for a coin or Manage
// S_MANAGE   | operator programming prices / refilling stock
// S_CREDIT   | credit held, waiting for a valid selection or Return
// S_SELECTED | product latched, waiting for Start
// S_MAKING   | brewer running until Done
// S_SERVE    | product at outlet until TakeOut
// S_CHANGE   | ejecting one coin per cycle until credit is zero
module vend_core_multi
  import vend_pkg::*;
#(
  parameter int N_PROD  = 4,
  parameter int SUM_W   = 8,
  parameter int STOCK_W = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Coin50,
  input  logic                      Coin100,
  input  logic                      Coin500,
  input  logic                      Coin1000,
  input  logic [N_PROD-1:0]         Sel,
  input  logic                      Start,
  input  logic                      Done,
  input  logic                      TakeOut,
  input  logic                      Return,
  input  logic                      Manage,
  input  logic                      Confirm,
  input  logic [$clog2(N_PROD)-1:0] PriceIdx,
  input  logic [SUM_W-1:0]          PriceIn,
  output logic                      Return50,
  output logic                      Return100,
  output logic                      Return500,
  output logic                      Return1000,
  output logic                      Making,
  output logic                      Coffee,
  output logic [SUM_W-1:0]          Sum,
  output logic [N_PROD-1:0]         SelOut,
  output logic [N_PROD-1:0]         SoldOut
);

  localparam int IDX_W = $clog2(N_PROD);
  localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};

  state_e               state_q;
  logic [SUM_W-1:0]     sum_q;
  logic [N_PROD-1:0]    sel_q;
  logic [IDX_W-1:0]     sel_idx_q;
  logic [3:0]           ret_q;
  logic                 making_q;
  logic                 coffee_q;

  logic [SUM_W-1:0]     price_q [N_PROD];
  logic [STOCK_W-1:0]   stock_q [N_PROD];
  logic [N_PROD-1:0]    sold_q;

  logic [3:0]           coin_oh;
  logic                 coin_en;
  logic [SUM_W:0]       sum_ext;
  logic                 coin_take;
  logic                 coin_rej;
  logic [SUM_W-1:0]     sum_coin_d;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_ok;
  logic                 vend_go;
  logic                 cfg_wr;
  logic [3:0]           chg_eject;
  logic [SUM_W-1:0]     chg_sub;

  vend_change_dispenser #(.SUM_W(SUM_W)) u_change (
    .sum_i   (sum_q),
    .eject_o (chg_eject),
    .sub_o   (chg_sub)
  );

  assign coin_oh = coin_pick({Coin1000, Coin500, Coin100, Coin50});
  assign coin_en = ((state_q == S_IDLE) && !Manage) ||
                   (state_q == S_CREDIT) || (state_q == S_SELECTED);
  assign sum_ext = {1'b0, sum_q} + (SUM_W+1)'(coin_units(coin_oh));

  // The extra carry bit flags a coin that would wrap the credit register.
  assign coin_take  = coin_en && (|coin_oh) && !sum_ext[SUM_W];
  assign coin_rej   = coin_en && (|coin_oh) &&  sum_ext[SUM_W];
  assign sum_coin_d = coin_take ? sum_ext[SUM_W-1:0] : sum_q;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (Sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_ok  = $onehot(Sel) && !sold_q[sel_idx] && (price_q[sel_idx] <= sum_q);
  assign vend_go = (state_q == S_SELECTED) && Start && !Return;
  assign cfg_wr  = (state_q == S_MANAGE) && Confirm && (int'(PriceIdx) < N_PROD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_PROD; i++) begin
        price_q[i] <= '0;
        stock_q[i] <= '0;
      end
      sold_q <= '1;
    end else begin
      if (cfg_wr) begin
        price_q[PriceIdx] <= PriceIn;
        stock_q[PriceIdx] <= STOCK_MAX;
        sold_q[PriceIdx]  <= (PriceIn == '0);
      end
      if (vend_go) begin
        stock_q[sel_idx_q] <= stock_q[sel_idx_q] - STOCK_W'(1);
        sold_q[sel_idx_q]  <= (stock_q[sel_idx_q] == STOCK_W'(1));
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      sum_q     <= '0;
      sel_q     <= '0;
      sel_idx_q <= '0;
      ret_q     <= '0;
      making_q  <= 1'b0;
      coffee_q  <= 1'b0;
    end else begin
      ret_q <= coin_rej ? coin_oh : 4'b0000;
      case (state_q)
        S_IDLE: begin
          if (Manage) begin
            state_q <= S_MANAGE;
          end else if (coin_take) begin
            sum_q   <= sum_coin_d;
            state_q <= S_CREDIT;
          end
        end
        S_MANAGE: begin
          if (Manage) state_q <= S_IDLE;
        end
        S_CREDIT: begin
          sum_q <= sum_coin_d;
          if (Return) begin
            state_q <= (sum_coin_d == '0) ? S_IDLE : S_CHANGE;
          end else if (sel_ok) begin
            sel_q     <= Sel;
            sel_idx_q <= sel_idx;
            state_q   <= S_SELECTED;
          end
        end
        S_SELECTED: begin
          if (Return) begin
            sum_q   <= sum_coin_d;
            sel_q   <= '0;
            state_q <= (sum_coin_d == '0) ? S_IDLE : S_CHANGE;
          end else if (Start) begin
            sum_q    <= sum_coin_d - price_q[sel_idx_q];
            making_q <= 1'b1;
            state_q  <= S_MAKING;
          end else begin
            sum_q <= sum_coin_d;
            if (sel_ok) begin
              sel_q     <= Sel;
              sel_idx_q <= sel_idx;
            end
          end
        end
        S_MAKING: begin
          if (Done) begin
            making_q <= 1'b0;
            coffee_q <= 1'b1;
            state_q  <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (TakeOut) begin
            coffee_q <= 1'b0;
            sel_q    <= '0;
            state_q  <= (sum_q != '0) ? S_CREDIT : S_IDLE;
          end
        end
        S_CHANGE: begin
          ret_q <= chg_eject;
          sum_q <= sum_q - chg_sub;
          if (sum_q == chg_sub) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Return50   = ret_q[C50];
  assign Return100  = ret_q[C100];
  assign Return500  = ret_q[C500];
  assign Return1000 = ret_q[C1000];
  assign Making     = making_q;
  assign Coffee     = coffee_q;
  assign Sum        = sum_q;
  assign SelOut     = sel_q;
  assign SoldOut    = sold_q;

endmodule

// File: tb/tb_vend_core_multi.sv
// Directed bench for vend_core_multi: a vector table for the main flow plus
// hand sequences for long change, overflow, stock exhaustion and async reset.
module tb_vend_core_multi;

  localparam logic [3:0] K50 = 4'b0001, K100 = 4'b0010, K500 = 4'b0100, K1000 = 4'b1000;
  localparam logic [5:0] K_START = 6'b100000, K_DONE = 6'b010000, K_TAKE = 6'b001000;
  localparam logic [5:0] K_RET = 6'b000100, K_MAN = 6'b000010, K_CONF = 6'b000001;

  logic       CLK, RST;
  logic       Coin50, Coin100, Coin500, Coin1000;
  logic [3:0] Sel;
  logic       Start, Done, TakeOut, Return, Manage, Confirm;
  logic [1:0] PriceIdx;
  logic [7:0] PriceIn;
  logic       Return50, Return100, Return500, Return1000, Making, Coffee;
  logic [7:0] Sum;
  logic [3:0] SelOut, SoldOut;

  int n_checks = 0;
  int n_fail   = 0;

  vend_core_multi dut (
    .CLK(CLK), .RST(RST),
    .Coin50(Coin50), .Coin100(Coin100), .Coin500(Coin500), .Coin1000(Coin1000),
    .Sel(Sel), .Start(Start), .Done(Done), .TakeOut(TakeOut), .Return(Return),
    .Manage(Manage), .Confirm(Confirm), .PriceIdx(PriceIdx), .PriceIn(PriceIn),
    .Return50(Return50), .Return100(Return100), .Return500(Return500),
    .Return1000(Return1000), .Making(Making), .Coffee(Coffee),
    .Sum(Sum), .SelOut(SelOut), .SoldOut(SoldOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [3:0] coin;
    logic [3:0] sel;
    logic [5:0] ctl;
    logic [1:0] pidx;
    logic [7:0] pin;
    logic [7:0] e_sum;
    logic [3:0] e_sel;
    logic [3:0] e_sold;
    logic [3:0] e_ret;
    logic       e_mk;
    logic       e_cf;
  } vec_t;

  vec_t vq[$];

  function automatic logic [21:0] outs();
    return {Sum, SelOut, SoldOut, Return1000, Return500, Return100, Return50, Making, Coffee};
  endfunction

  task automatic add(input string nm, input logic [3:0] c, input logic [3:0] s,
                     input logic [5:0] k, input logic [1:0] pi, input logic [7:0] pn,
                     input logic [7:0] es, input logic [3:0] esel, input logic [3:0] esold,
                     input logic [3:0] eret, input logic emk, input logic ecf);
    vec_t v;
    v.name = nm; v.coin = c; v.sel = s; v.ctl = k; v.pidx = pi; v.pin = pn;
    v.e_sum = es; v.e_sel = esel; v.e_sold = esold; v.e_ret = eret; v.e_mk = emk; v.e_cf = ecf;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [21:0] exp);
    logic [21:0] got;
    got = outs();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got sum=%0d sel=%b sold=%b ret=%b mk=%b cf=%b, want sum=%0d sel=%b sold=%b ret=%b mk=%b cf=%b",
               nm, got[21:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
               exp[21:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  // Called at a falling edge: drive for one rising edge, return at the next falling edge.
  task automatic step(input logic [3:0] c, input logic [3:0] s, input logic [5:0] k,
                      input logic [1:0] pi, input logic [7:0] pn);
    {Coin1000, Coin500, Coin100, Coin50} = c;
    Sel = s;
    {Start, Done, TakeOut, Return, Manage, Confirm} = k;
    PriceIdx = pi;
    PriceIn  = pn;
    @(posedge CLK);
    @(negedge CLK);
    {Coin1000, Coin500, Coin100, Coin50} = 4'b0;
    Sel = 4'b0;
    {Start, Done, TakeOut, Return, Manage, Confirm} = 6'b0;
    PriceIdx = 2'd0;
    PriceIn  = 8'd0;
  endtask

  task automatic idle1();
    step(4'b0, 4'b0, 6'b0, 2'd0, 8'd0);
  endtask

  initial begin
    logic [3:0] chg_ret [4];
    logic [7:0] chg_sum [4];
    int pulses, cycles;

    add("idle_nop",      4'b0,      4'b0,   6'b0,            2'd0, 8'd0, 8'd0,  4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
    add("mgr_enter",     4'b0,      4'b0,   K_MAN,           2'd0, 8'd0, 8'd0,  4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
    add("prog0",         4'b0,      4'b0,   K_CONF,          2'd0, 8'd4, 8'd0,  4'b0000, 4'b1110, 4'b0000, 1'b0, 1'b0);
    add("prog1",         4'b0,      4'b0,   K_CONF,          2'd1, 8'd6, 8'd0,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("mgr_coin_ign",  K100,      4'b0,   6'b0,            2'd0, 8'd0, 8'd0,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("mgr_exit",      4'b0,      4'b0,   K_MAN,           2'd0, 8'd0, 8'd0,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("coin_a",        K100,      4'b0,   6'b0,            2'd0, 8'd0, 8'd2,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("coin_b",        K100,      4'b0,   6'b0,            2'd0, 8'd0, 8'd4,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("coin_c",        K100,      4'b0,   6'b0,            2'd0, 8'd0, 8'd6,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("sel0",          4'b0,      4'b0001, 6'b0,           2'd0, 8'd0, 8'd6,  4'b0001, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("start",         4'b0,      4'b0,   K_START,         2'd0, 8'd0, 8'd2,  4'b0001, 4'b1100, 4'b0000, 1'b1, 1'b0);
    add("making_hold",   4'b0,      4'b0,   6'b0,            2'd0, 8'd0, 8'd2,  4'b0001, 4'b1100, 4'b0000, 1'b1, 1'b0);
    add("done",          4'b0,      4'b0,   K_DONE,          2'd0, 8'd0, 8'd2,  4'b0001, 4'b1100, 4'b0000, 1'b0, 1'b1);
    add("takeout",       4'b0,      4'b0,   K_TAKE,          2'd0, 8'd0, 8'd2,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("sel1_short",    4'b0,      4'b0010, 6'b0,           2'd0, 8'd0, 8'd2,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("sel_price0",    4'b0,      4'b0100, 6'b0,           2'd0, 8'd0, 8'd2,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("ret_sum2",      4'b0,      4'b0,   K_RET,           2'd0, 8'd0, 8'd2,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("chg_100",       4'b0,      4'b0,   6'b0,            2'd0, 8'd0, 8'd0,  4'b0000, 4'b1100, K100,    1'b0, 1'b0);
    add("idle_coin50",   K50,       4'b0,   6'b0,            2'd0, 8'd0, 8'd1,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("coin100",       K100,      4'b0,   6'b0,            2'd0, 8'd0, 8'd3,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("sel1_sum3",     4'b0,      4'b0010, 6'b0,           2'd0, 8'd0, 8'd3,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("coin_prio",     K50|K100,  4'b0,   6'b0,            2'd0, 8'd0, 8'd5,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("sel1_sum5",     4'b0,      4'b0010, 6'b0,           2'd0, 8'd0, 8'd5,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("coin50",        K50,       4'b0,   6'b0,            2'd0, 8'd0, 8'd6,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("sel_multi",     4'b0,      4'b0011, 6'b0,           2'd0, 8'd0, 8'd6,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("sel1",          4'b0,      4'b0010, 6'b0,           2'd0, 8'd0, 8'd6,  4'b0010, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("resel0",        4'b0,      4'b0001, 6'b0,           2'd0, 8'd0, 8'd6,  4'b0001, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("ret_over_start",4'b0,      4'b0,   K_START|K_RET,   2'd0, 8'd0, 8'd6,  4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("chg6_a",        4'b0,      4'b0,   6'b0,            2'd0, 8'd0, 8'd4,  4'b0000, 4'b1100, K100,    1'b0, 1'b0);
    add("chg6_b",        4'b0,      4'b0,   6'b0,            2'd0, 8'd0, 8'd2,  4'b0000, 4'b1100, K100,    1'b0, 1'b0);
    add("chg6_c",        4'b0,      4'b0,   6'b0,            2'd0, 8'd0, 8'd0,  4'b0000, 4'b1100, K100,    1'b0, 1'b0);
    add("coin1000",      K1000,     4'b0,   6'b0,            2'd0, 8'd0, 8'd20, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("manage_ign",    K50,       4'b0,   K_MAN,           2'd0, 8'd0, 8'd21, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("confirm_ign",   4'b0,      4'b0,   K_CONF,          2'd2, 8'd3, 8'd21, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("coin500",       K500,      4'b0,   6'b0,            2'd0, 8'd0, 8'd31, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);
    add("coin100_33",    K100,      4'b0,   6'b0,            2'd0, 8'd0, 8'd33, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0);

    RST = 1'b1;
    {Coin1000, Coin500, Coin100, Coin50} = 4'b0;
    Sel = 4'b0;
    {Start, Done, TakeOut, Return, Manage, Confirm} = 6'b0;
    PriceIdx = 2'd0;
    PriceIn  = 8'd0;
    repeat (3) @(negedge CLK);
    chk("reset", {8'd0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0});
    RST = 1'b0;
    @(negedge CLK);

    foreach (vq[i]) begin
      step(vq[i].coin, vq[i].sel, vq[i].ctl, vq[i].pidx, vq[i].pin);
      chk(vq[i].name, {vq[i].e_sum, vq[i].e_sel, vq[i].e_sold, vq[i].e_ret, vq[i].e_mk, vq[i].e_cf});
    end

    // Return of 33 units: 1000, 500, 100, 50 on consecutive cycles.
    chg_ret[0] = K1000; chg_sum[0] = 8'd13;
    chg_ret[1] = K500;  chg_sum[1] = 8'd3;
    chg_ret[2] = K100;  chg_sum[2] = 8'd1;
    chg_ret[3] = K50;   chg_sum[3] = 8'd0;
    step(4'b0, 4'b0, K_RET, 2'd0, 8'd0);
    chk("ret33_req", {8'd33, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      idle1();
      chk($sformatf("ret33_%0d", i), {chg_sum[i], 4'b0000, 4'b1100, chg_ret[i], 1'b0, 1'b0});
    end
    idle1();
    chk("ret33_quiet", {8'd0, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0});

    // Credit overflow near the top of an 8-bit register.
    repeat (12) step(K1000, 4'b0, 6'b0, 2'd0, 8'd0);
    step(K500, 4'b0, 6'b0, 2'd0, 8'd0);
    chk("sum250", {8'd250, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0});
    step(K1000, 4'b0, 6'b0, 2'd0, 8'd0);
    chk("ovf_1000", {8'd250, 4'b0000, 4'b1100, K1000, 1'b0, 1'b0});
    idle1();
    chk("ovf_clear", {8'd250, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0});
    step(K500, 4'b0, 6'b0, 2'd0, 8'd0);
    chk("ovf_500", {8'd250, 4'b0000, 4'b1100, K500, 1'b0, 1'b0});
    step(K100, 4'b0, 6'b0, 2'd0, 8'd0);
    chk("fit_252", {8'd252, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0});
    step(4'b0, 4'b0, K_RET, 2'd0, 8'd0);
    pulses = 0;
    cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      idle1();
      cycles = k;
      if ({Return1000, Return500, Return100, Return50} != 4'b0) pulses++;
      if (Sum == 8'd0) break;
    end
    chk_int("chg252_cycles", cycles, 14);
    chk_int("chg252_pulses", pulses, 14);

    // Exhaust stock on product 0 (price 1, refilled to 15).
    step(4'b0, 4'b0, K_MAN, 2'd0, 8'd0);
    step(4'b0, 4'b0, K_CONF, 2'd0, 8'd1);
    step(4'b0, 4'b0, K_MAN, 2'd0, 8'd0);
    chk("refill0", {8'd0, 4'b0000, 4'b1100, 4'b0000, 1'b0, 1'b0});
    for (int n = 1; n <= 15; n++) begin
      step(K50, 4'b0, 6'b0, 2'd0, 8'd0);
      step(4'b0, 4'b0001, 6'b0, 2'd0, 8'd0);
      step(4'b0, 4'b0, K_START, 2'd0, 8'd0);
      chk($sformatf("vend%0d", n), {8'd0, 4'b0001, (n == 15) ? 4'b1101 : 4'b1100, 4'b0000, 1'b1, 1'b0});
      step(4'b0, 4'b0, K_DONE, 2'd0, 8'd0);
      step(4'b0, 4'b0, K_TAKE, 2'd0, 8'd0);
    end
    step(K50, 4'b0, 6'b0, 2'd0, 8'd0);
    step(4'b0, 4'b0001, 6'b0, 2'd0, 8'd0);
    chk("sel_soldout", {8'd1, 4'b0000, 4'b1101, 4'b0000, 1'b0, 1'b0});

    // Asynchronous reset while the brewer is running.
    repeat (3) step(K100, 4'b0, 6'b0, 2'd0, 8'd0);
    step(4'b0, 4'b0010, 6'b0, 2'd0, 8'd0);
    step(4'b0, 4'b0, K_START, 2'd0, 8'd0);
    chk("pre_reset_making", {8'd1, 4'b0010, 4'b1101, 4'b0000, 1'b1, 1'b0});
    #2 RST = 1'b1;
    #1;
    chk("async_reset", {8'd0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0});
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
